// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: latches sw on an enviar press, lets the ALU settle, then issues one rf_we.
// Optional feature macro DEBOUNCE_EN adds a DEB_CYCLES stable-time filter on the synchronized button.
module instr_sequencer #(
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_W       = 8,
  parameter int DEB_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ligar,
  input  logic             enviar,
  input  logic [17:0]      sw,
  input  logic             uc_write_enable,
  output logic [17:0]      instr,
  output logic             rf_we,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  // state | meaning
  // OFF   | powered down, waiting for ligar
  // IDLE  | waiting for a button press
  // LATCH | instr captured, UC decoding
  // EXEC  | ALU settle, EXEC_CYCLES cycles
  // WRITE | register-file write strobe
  // DONE  | completion pulse, count update
  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_IDLE  = 3'd1,
    S_LATCH = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  if (EXEC_CYCLES < 1 || DEB_CYCLES < 1) begin : g_bad_params
    $error("instr_sequencer: EXEC_CYCLES and DEB_CYCLES must be >= 1");
  end

  state_t            r_state;
  logic [EW-1:0]     r_exec_cnt;
  logic [17:0]       r_instr;
  logic              r_rf_we;
  logic              r_busy;
  logic              r_done;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_count;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_lvl_d;
  logic              w_level;
  logic              w_press;
  logic              w_illegal_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_lvl_d <= 1'b1;
    end else begin
      r_sync1 <= enviar;
      r_sync2 <= r_sync1;
      r_lvl_d <= w_level;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  logic [DW-1:0] r_deb_cnt;
  logic          r_deb_lvl;

  // Level only flips after DEB_CYCLES consecutive samples disagreeing with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_cnt <= DW'(DEB_CYCLES - 1);
      r_deb_lvl <= 1'b1;
    end else if (r_sync2 == r_deb_lvl) begin
      r_deb_cnt <= DW'(DEB_CYCLES - 1);
    end else if (r_deb_cnt == '0) begin
      r_deb_lvl <= r_sync2;
      r_deb_cnt <= DW'(DEB_CYCLES - 1);
    end else begin
      r_deb_cnt <= r_deb_cnt - 1'b1;
    end
  end

  assign w_level = r_deb_lvl;
`else
  assign w_level = r_sync2;
`endif

  assign w_press      = r_lvl_d & ~w_level;
  assign w_illegal_op = (r_instr[17:15] == 3'b111);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_OFF;
      r_exec_cnt <= '0;
      r_instr    <= '0;
      r_rf_we    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_rf_we <= 1'b0;
      r_done  <= 1'b0;
      // Power-off wins over any press and aborts without strobes.
      if (!ligar) begin
        r_state <= S_OFF;
        r_instr <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_OFF: r_state <= S_IDLE;
          S_IDLE: begin
            if (w_press) begin
              r_state   <= S_LATCH;
              r_instr   <= sw;
              r_illegal <= 1'b0;
              r_busy    <= 1'b1;
            end
          end
          S_LATCH: begin
            r_state    <= S_EXEC;
            r_exec_cnt <= EW'(EXEC_CYCLES - 1);
          end
          S_EXEC: begin
            if (r_exec_cnt == '0) begin
              r_state   <= S_WRITE;
              r_rf_we   <= uc_write_enable & ~w_illegal_op;
              r_illegal <= w_illegal_op;
            end else begin
              r_exec_cnt <= r_exec_cnt - 1'b1;
            end
          end
          S_WRITE: begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_count <= r_count + 1'b1;
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_OFF;
        endcase
      end
    end
  end

  assign instr       = r_instr;
  assign rf_we       = r_rf_we;
  assign busy        = r_busy;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign instr_count = r_count;
  assign state       = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer; a second instance with CNT_W=4 checks counter wrap.
module tb_instr_sequencer;

`ifdef DEBOUNCE_EN
  localparam int DL = 4;
`else
  localparam int DL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, ligar, enviar, uc_we;
  logic [17:0] sw;
  logic [17:0] instr, instr4;
  logic        rf_we, busy, done, illegal;
  logic        rf_we4, busy4, done4, illegal4;
  logic [7:0]  count;
  logic [3:0]  count4;
  logic [2:0]  state, state4;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int exp_cnt = 0;
  int w0, d0;

  localparam logic [17:0] SW_ADDI = 18'b010_0001_0010_0_000101;
  localparam logic [17:0] SW_ILL  = 18'b111_0001_0010_0_000000;
  localparam logic [17:0] SW_CLR  = 18'b110_0011_0000_0_000000;

  always #5 clk = ~clk;

  instr_sequencer #(.EXEC_CYCLES(2), .CNT_W(8), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ligar(ligar), .enviar(enviar), .sw(sw),
    .uc_write_enable(uc_we), .instr(instr), .rf_we(rf_we), .busy(busy),
    .done(done), .illegal(illegal), .instr_count(count), .state(state)
  );

  instr_sequencer #(.EXEC_CYCLES(2), .CNT_W(4), .DEB_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .ligar(ligar), .enviar(enviar), .sw(sw),
    .uc_write_enable(uc_we), .instr(instr4), .rf_we(rf_we4), .busy(busy4),
    .done(done4), .illegal(illegal4), .instr_count(count4), .state(state4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (rf_we) we_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [17:0] s, input logic we, input int exp_we);
    int w, d;
    sw = s;
    uc_we = we;
    w = we_cnt;
    d = done_cnt;
    enviar = 1'b0;
    repeat (2 + DL) tick();
    enviar = 1'b1;
    repeat (6) tick();
    exp_cnt++;
    check("op_rf_we", we_cnt - w, exp_we);
    check("op_done", done_cnt - d, 1);
    check("op_state", {29'd0, state}, 1);
    check("op_count", {24'd0, count}, exp_cnt % 256);
    check("op_count4", {28'd0, count4}, exp_cnt % 16);
    repeat (6 + DL) tick();
  endtask

  initial begin
    rst = 1'b1; ligar = 1'b0; enviar = 1'b1; uc_we = 1'b0; sw = '0;
    repeat (2) tick();
    check("rst_state", {29'd0, state}, 0);
    check("rst_instr", {14'd0, instr}, 0);
    check("rst_outs", {28'd0, rf_we, busy, done, illegal}, 0);
    check("rst_count", {24'd0, count}, 0);
    rst = 1'b0;
    ligar = 1'b1;
    tick();
    check("off_to_idle", {29'd0, state}, 1);

    // 1: ADDI with exact latency
    sw = SW_ADDI; uc_we = 1'b1;
    w0 = we_cnt;
    enviar = 1'b0;
    repeat (2 + DL) tick();
    check("t1_pre_latch", {29'd0, state}, 1);
    tick();
    check("t1_latch", {29'd0, state}, 2);
    check("t1_instr", {14'd0, instr}, {14'd0, SW_ADDI});
    check("t1_busy", {31'd0, busy}, 1);
    tick();
    check("t1_exec_a", {29'd0, state}, 3);
    tick();
    check("t1_exec_b", {28'd0, state, rf_we}, {28'd0, 3'd3, 1'b0});
    tick();
    check("t1_write", {28'd0, state, rf_we}, {28'd0, 3'd4, 1'b1});
    tick();
    check("t1_done", {27'd0, state, rf_we, done}, {27'd0, 3'd5, 1'b0, 1'b1});
    check("t1_count", {24'd0, count}, 1);
    tick();
    check("t1_idle", {28'd0, state, busy}, {28'd0, 3'd1, 1'b0});
    check("t1_we_total", we_cnt - w0, 1);
    exp_cnt = 1;
    enviar = 1'b1;
    repeat (6 + DL) tick();

    // 2: illegal opcode, then next press clears illegal
    do_op(SW_ILL, 1'b1, 0);
    check("t2_illegal", {31'd0, illegal}, 1);
    sw = SW_ADDI; uc_we = 1'b1;
    enviar = 1'b0;
    repeat (3 + DL) tick();
    check("t2_clear", {28'd0, state, illegal}, {28'd0, 3'd2, 1'b0});
    repeat (5) tick();
    exp_cnt++;
    enviar = 1'b1;
    repeat (6 + DL) tick();
    check("t2_count", {24'd0, count}, exp_cnt);

    // 3: re-press during the op and a long hold give one write
    w0 = we_cnt; d0 = done_cnt;
    enviar = 1'b0;
    repeat (2 + DL) tick();
    enviar = 1'b1;
    repeat (2) tick();
    enviar = 1'b0;
    repeat (22) tick();
    enviar = 1'b1;
    repeat (6 + DL) tick();
    exp_cnt++;
    check("t3_we", we_cnt - w0, 1);
    check("t3_done", done_cnt - d0, 1);
    check("t3_count", {24'd0, count}, exp_cnt);

    // 4: ligar drop in EXEC aborts
    w0 = we_cnt; d0 = done_cnt;
    sw = SW_CLR;
    enviar = 1'b0;
    repeat (2 + DL) tick();
    repeat (2) tick();
    check("t4_exec", {29'd0, state}, 3);
    ligar = 1'b0;
    tick();
    check("t4_off", {28'd0, state, busy}, 0);
    check("t4_instr", {14'd0, instr}, 0);
    repeat (3) tick();
    check("t4_no_strobe", (we_cnt - w0) + (done_cnt - d0), 0);
    check("t4_count", {24'd0, count}, exp_cnt);
    ligar = 1'b1;
    tick();
    check("t4_idle", {29'd0, state}, 1);
    repeat (5) tick();
    check("t4_hold_no_press", {29'd0, state}, 1);
    enviar = 1'b1;
    repeat (6 + DL) tick();

    // 5: back-to-back ops with wrap on the 4-bit counter, then rst mid-EXEC
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 0) do_op(SW_CLR, 1'b1, 1);
      else if (i % 3 == 1) do_op(SW_ADDI, 1'b0, 0);
      else do_op(SW_ADDI ^ 18'(i), 1'b1, 1);
    end
    check("t5_wrap4", {28'd0, count4}, exp_cnt % 16);
    w0 = we_cnt;
    enviar = 1'b0;
    repeat (4 + DL) tick();
    check("t5_exec", {29'd0, state}, 3);
    rst = 1'b1;
    tick();
    check("t5_rst_state", {26'd0, state, state4}, 0);
    check("t5_rst_instr", {14'd0, instr}, 0);
    check("t5_rst_count", {20'd0, count, count4}, 0);
    check("t5_rst_outs", {28'd0, rf_we, busy, done, illegal}, 0);
    rst = 1'b0;
    enviar = 1'b1;
    exp_cnt = 0;
    repeat (6 + DL) tick();
    check("t5_no_we", we_cnt - w0, 0);

    // 6: short glitch (filtered only with debounce), then a 6-cycle press
    d0 = done_cnt;
    enviar = 1'b0;
    repeat (2) tick();
    enviar = 1'b1;
    repeat (14) tick();
    check("t6_glitch", done_cnt - d0, (DL > 0) ? 0 : 1);
    if (DL == 0) exp_cnt++;
    d0 = done_cnt;
    enviar = 1'b0;
    repeat (6) tick();
    enviar = 1'b1;
    repeat (14) tick();
    exp_cnt++;
    check("t6_press", done_cnt - d0, 1);
    check("t6_count", {24'd0, count}, exp_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
